// File: rtl/int_ctrl.sv
// Programmable interrupt controller: per-source edge/level latching, mask, fixed
// priority (lowest index wins), one request in service until software writes EOI.
module int_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] irq_in,
    input  logic            int_ack,
    output logic [NSRC-1:0] HWInt
);

    typedef enum logic {
        IDLE,
        SERVICE
    } state_t;

    state_t          state;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] irq_prev;
    logic [2:0]      id;

    logic [NSRC-1:0] active;
    logic [NSRC-1:0] top_onehot;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] pend_next;
    logic [2:0]      top_idx;
    logic            found;
    logic            take;
    logic            eoi;
    logic            unused_bits;

    assign unused_bits = ^{Addr[31:4], Din[31:NSRC]};

    always_comb begin
        active  = pend & mask;
        found   = 1'b0;
        top_idx = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (active[i] && !found) begin
                found   = 1'b1;
                top_idx = 3'(i);
            end
        end
        top_onehot = found ? ({{(NSRC-1){1'b0}}, 1'b1} << top_idx) : '0;
    end

    assign take = (state == IDLE) && int_ack && found;
    assign eoi  = (state == SERVICE) && WE && (Addr[3:2] == 2'd3);

    // Edge bits: a new rising edge beats any clear in the same cycle.
    // Level bits simply track the registered input.
    always_comb begin
        rise      = irq_in & ~irq_prev;
        w1c       = (WE && (Addr[3:2] == 2'd0)) ? Din[NSRC-1:0] : '0;
        ack_clr   = take ? top_onehot : '0;
        pend_next = (mode & (rise | (pend & ~(w1c | ack_clr)))) | (~mode & irq_in);
    end

    always_comb begin
        HWInt = (state == IDLE) ? top_onehot : '0;
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'd0: Dout = {{(32-NSRC){1'b0}}, pend};
            2'd1: Dout = {{(32-NSRC){1'b0}}, mask};
            2'd2: Dout = {{(32-NSRC){1'b0}}, mode};
            2'd3: Dout = {(state == SERVICE), 28'b0, id};
            default: Dout = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pend     <= '0;
            mask     <= '0;
            mode     <= '0;
            irq_prev <= '0;
            id       <= '0;
        end else begin
            irq_prev <= irq_in;
            pend     <= pend_next;
            if (WE && (Addr[3:2] == 2'd1)) mask <= Din[NSRC-1:0];
            if (WE && (Addr[3:2] == 2'd2)) mode <= Din[NSRC-1:0];
            case (state)
                IDLE: begin
                    if (take) begin
                        id    <= top_idx;
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; inputs driven on falling edges,
// outputs sampled before the next rising edge.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  irq_in;
    logic        int_ack;
    logic [5:0]  HWInt;

    int tests = 0;
    int fails = 0;

    int_ctrl #(.NSRC(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .irq_in  (irq_in),
        .int_ack (int_ack),
        .HWInt   (HWInt)
    );

    always #5 clk = ~clk;

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        Addr = 30'(a);
        Din  = d;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; WE = 1'b0; Din = '0; Addr = '0; irq_in = '0; int_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL reset_hwint got %h want %h", HWInt, 6'b0); end
        for (int a = 0; a < 4; a++) begin
            Addr = 30'(a); #1;
            tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL reset_dout%0d got %h want %h", a, Dout, 32'h0); end
        end
    endtask

    task automatic test_level();
        @(negedge clk);
        write_reg(2'd1, 32'h3F);
        irq_in = 6'b000110;
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL level_pre got %b want %b", HWInt, 6'b0); end
        @(negedge clk);
        tests++; if (HWInt !== 6'b000010) begin fails++; $display("FAIL level_hwint got %b want %b", HWInt, 6'b000010); end
        Addr = 30'd3; #1;
        tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL level_cur got %h want %h", Dout, 32'h0); end
        Addr = 30'd0; #1;
        tests++; if (Dout !== 32'h6) begin fails++; $display("FAIL level_pend got %h want %h", Dout, 32'h6); end
    endtask

    task automatic test_ack_eoi();
        @(negedge clk);
        pulse_ack();
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL ack_hwint got %b want %b", HWInt, 6'b0); end
        Addr = 30'd3; #1;
        tests++; if (Dout !== 32'h8000_0001) begin fails++; $display("FAIL ack_cur got %h want %h", Dout, 32'h8000_0001); end
        @(negedge clk);
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL svc_hold got %b want %b", HWInt, 6'b0); end
        write_reg(2'd3, 32'h0);
        tests++; if (HWInt !== 6'b000010) begin fails++; $display("FAIL eoi_hwint got %b want %b", HWInt, 6'b000010); end
        #1;
        tests++; if (Dout !== 32'h0000_0001) begin fails++; $display("FAIL eoi_cur got %h want %h", Dout, 32'h1); end
        irq_in = 6'b0;
        @(negedge clk);
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL level_drop got %b want %b", HWInt, 6'b0); end
    endtask

    task automatic test_edge();
        @(negedge clk);
        write_reg(2'd2, 32'h01);
        write_reg(2'd1, 32'h01);
        irq_in = 6'b000001;
        @(negedge clk);
        irq_in = 6'b0;
        repeat (3) @(negedge clk);
        Addr = 30'd0; #1;
        tests++; if (Dout !== 32'h1) begin fails++; $display("FAIL edge_latch got %h want %h", Dout, 32'h1); end
        tests++; if (HWInt !== 6'b000001) begin fails++; $display("FAIL edge_hwint got %b want %b", HWInt, 6'b000001); end
        @(negedge clk);
        pulse_ack();
        Addr = 30'd0; #1;
        tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL edge_ackclr got %h want %h", Dout, 32'h0); end
        Addr = 30'd3; #1;
        tests++; if (Dout !== 32'h8000_0000) begin fails++; $display("FAIL edge_cur got %h want %h", Dout, 32'h8000_0000); end
        write_reg(2'd3, 32'h0);
        irq_in = 6'b000001;
        @(negedge clk);
        tests++; if (HWInt !== 6'b000001) begin fails++; $display("FAIL edge_hold_set got %b want %b", HWInt, 6'b000001); end
        pulse_ack();
        repeat (10) @(negedge clk);
        Addr = 30'd0; #1;
        tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL edge_hold_once got %h want %h", Dout, 32'h0); end
        write_reg(2'd3, 32'h0);
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL edge_hold_eoi got %b want %b", HWInt, 6'b0); end
        irq_in = 6'b0;
        @(negedge clk);
    endtask

    task automatic test_w1c_race();
        @(negedge clk);
        irq_in = 6'b000001;
        @(negedge clk);
        irq_in = 6'b0;
        @(negedge clk);
        irq_in = 6'b000001;
        write_reg(2'd0, 32'h1);
        #1;
        tests++; if (Dout !== 32'h1) begin fails++; $display("FAIL w1c_race got %h want %h", Dout, 32'h1); end
        write_reg(2'd0, 32'h1);
        #1;
        tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL w1c_clear got %h want %h", Dout, 32'h0); end
        irq_in = 6'b0;
        @(negedge clk);
    endtask

    task automatic test_mask();
        @(negedge clk);
        write_reg(2'd2, 32'h0);
        write_reg(2'd1, 32'h0);
        irq_in = 6'b000101;
        @(negedge clk);
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL mask_zero got %b want %b", HWInt, 6'b0); end
        write_reg(2'd0, 32'h3F);
        #1;
        tests++; if (Dout !== 32'h5) begin fails++; $display("FAIL level_w1c got %h want %h", Dout, 32'h5); end
        pulse_ack();
        Addr = 30'd3; #1;
        tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL ack_masked got %h want %h", Dout, 32'h0); end
        write_reg(2'd1, 32'h04);
        tests++; if (HWInt !== 6'b000100) begin fails++; $display("FAIL mask_one got %b want %b", HWInt, 6'b000100); end
        write_reg(2'd1, 32'h3F);
        tests++; if (HWInt !== 6'b000001) begin fails++; $display("FAIL priority got %b want %b", HWInt, 6'b000001); end
        pulse_ack();
        Addr = 30'd3; #1;
        tests++; if (Dout !== 32'h8000_0000) begin fails++; $display("FAIL prio_cur got %h want %h", Dout, 32'h8000_0000); end
    endtask

    task automatic test_reset_service();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL rst_svc_hwint got %b want %b", HWInt, 6'b0); end
        Addr = 30'd3; #1;
        tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL rst_svc_cur got %h want %h", Dout, 32'h0); end
        Addr = 30'd0; #1;
        tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL rst_svc_pend got %h want %h", Dout, 32'h0); end
        Addr = 30'd1; #1;
        tests++; if (Dout !== 32'h0) begin fails++; $display("FAIL rst_svc_mask got %h want %h", Dout, 32'h0); end
        reset  = 1'b0;
        irq_in = 6'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        write_reg(2'd1, 32'h3F);
        irq_in = 6'b000110;
        @(negedge clk);
        tests++; if (HWInt !== 6'b000010) begin fails++; $display("FAIL b2b_first got %b want %b", HWInt, 6'b000010); end
        pulse_ack();
        irq_in = 6'b000100;
        @(negedge clk);
        tests++; if (HWInt !== 6'b0) begin fails++; $display("FAIL b2b_svc got %b want %b", HWInt, 6'b0); end
        write_reg(2'd3, 32'h0);
        tests++; if (HWInt !== 6'b000100) begin fails++; $display("FAIL b2b_next got %b want %b", HWInt, 6'b000100); end
        pulse_ack();
        Addr = 30'd3; #1;
        tests++; if (Dout !== 32'h8000_0002) begin fails++; $display("FAIL b2b_cur got %h want %h", Dout, 32'h8000_0002); end
        write_reg(2'd3, 32'h0);
        irq_in = 6'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_level();
        test_ack_eoi();
        test_edge();
        test_w1c_race();
        test_mask();
        test_reset_service();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
